// File: rtl/d_mem_arb.sv
// Data-memory arbiter: CPU owns the port, debug/loader steals idle cycles.
// Define D_MEM_ARB_STARVE_EN to add the starvation counter and forced debug bursts.
module d_mem_arb #(
  parameter int WIDTH        = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic             dbg_lock,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_gnt,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_rvalid,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  logic w_cpu_gnt, w_dbg_gnt, w_stall;
  logic w_cpu_g, w_dbg_g;
  logic [WIDTH-1:0] r_dbg_rdata;
  logic             r_dbg_rvalid;

`ifdef D_MEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {S_CPU, S_DBG} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_nxt;
  logic [BW-1:0] r_burst_cnt, w_burst_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_CPU;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_burst_nxt  = r_burst_cnt;
    w_cpu_gnt    = cpu_req;
    w_dbg_gnt    = dbg_req & ~cpu_req;
    w_stall      = 1'b0;
    case (r_state)
      S_CPU: begin
        w_burst_nxt = '0;
        if (dbg_req & cpu_req) begin
          if (r_starve_cnt == SW'(STARVE_LIMIT - 1)) begin
            w_state_nxt  = S_DBG;
            w_starve_nxt = '0;
          end else begin
            w_starve_nxt = r_starve_cnt + 1'b1;
          end
        end else begin
          w_starve_nxt = '0;
        end
      end
      S_DBG: begin
        if (dbg_req) begin
          w_dbg_gnt = 1'b1;
          w_cpu_gnt = 1'b0;
          w_stall   = cpu_req;
          // Stay only while the master locks and the burst cap is not reached.
          if (dbg_lock && (r_burst_cnt < BW'(BURST_MAX - 1))) begin
            w_burst_nxt = r_burst_cnt + 1'b1;
          end else begin
            w_state_nxt = S_CPU;
            w_burst_nxt = '0;
          end
        end else begin
          w_state_nxt = S_CPU;
          w_burst_nxt = '0;
        end
      end
      default: w_state_nxt = S_CPU;
    endcase
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = dbg_lock;
  assign w_cpu_gnt     = cpu_req;
  assign w_dbg_gnt     = dbg_req & ~cpu_req;
  assign w_stall       = 1'b0;
`endif

  // Grants are forced off while reset is held so nothing reaches memory.
  assign w_cpu_g   = rst & w_cpu_gnt;
  assign w_dbg_g   = rst & w_dbg_gnt;
  assign cpu_stall = rst & w_stall;
  assign dbg_gnt   = w_dbg_g;

  assign mem_en    = w_cpu_g | w_dbg_g;
  assign mem_we    = (w_cpu_g & cpu_we) | (w_dbg_g & dbg_we);
  assign mem_addr  = w_cpu_g ? cpu_addr  : (w_dbg_g ? dbg_addr  : '0);
  assign mem_wdata = w_cpu_g ? cpu_wdata : (w_dbg_g ? dbg_wdata : '0);
  assign cpu_rdata = w_cpu_g ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_dbg_rvalid <= w_dbg_g & ~dbg_we;
      if (w_dbg_g & ~dbg_we) r_dbg_rdata <= mem_rdata;
    end
  end

  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;

endmodule

// File: tb/tb_d_mem_arb.sv
// Scoreboard bench for d_mem_arb: driver pushes per-cycle expectations from a
// rule-level model, a negedge monitor pops and compares against the DUT.
module tb_d_mem_arb;
  localparam int W  = 8;
  localparam int SL = 4;
  localparam int BM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [W-1:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic         cpu_stall;
  logic         dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [W-1:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
  logic         dbg_gnt, dbg_rvalid;
  logic         mem_en, mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  logic [W-1:0] tb_mem [256] = '{default: '0};

  d_mem_arb #(.WIDTH(W), .STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic         dg, st, en, we, rv;
    logic [W-1:0] addr, wd, crd, drd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [W-1:0] ref_mem [256] = '{default: '0};
  bit           m_forced = 0;
  int           m_conf = 0, m_burst = 0;
  logic         m_rv = 1'b0;
  logic [W-1:0] m_rd = '0;
  bit           last_dg = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dbg_gnt",    32'(dbg_gnt),    32'(e.dg));
      chk("cpu_stall",  32'(cpu_stall),  32'(e.st));
      chk("mem_en",     32'(mem_en),     32'(e.en));
      chk("mem_we",     32'(mem_we),     32'(e.we));
      chk("mem_addr",   32'(mem_addr),   32'(e.addr));
      chk("mem_wdata",  32'(mem_wdata),  32'(e.wd));
      chk("cpu_rdata",  32'(cpu_rdata),  32'(e.crd));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.rv));
      chk("dbg_rdata",  32'(dbg_rdata),  32'(e.drd));
    end
  end

  task automatic step(input logic r, input logic cr, input logic cw,
                      input logic [W-1:0] ca, input logic [W-1:0] cwd,
                      input logic dr, input logic dw, input logic dl,
                      input logic [W-1:0] da, input logic [W-1:0] dwd);
    exp_t e;
    bit   cg, dg, st;
    @(posedge clk);
    #1;
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
    dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dwd;
    e = '{default: '0};
    cg = 0; dg = 0; st = 0;
    if (!r) begin
      m_forced = 0; m_conf = 0; m_burst = 0; m_rv = 1'b0; m_rd = '0;
    end else begin
      e.rv = m_rv; e.drd = m_rd;
`ifdef D_MEM_ARB_STARVE_EN
      if (!m_forced) begin
        cg = cr; dg = dr && !cr;
        if (cr && dr) begin
          m_conf++;
          if (m_conf == SL) begin m_forced = 1; m_conf = 0; m_burst = 0; end
        end else m_conf = 0;
      end else if (dr) begin
        dg = 1; st = cr; m_burst++;
        if (!(dl && m_burst < BM)) begin m_forced = 0; m_burst = 0; end
      end else begin
        cg = cr; m_forced = 0; m_burst = 0;
      end
`else
      cg = cr; dg = dr && !cr;
`endif
      e.dg = dg; e.st = st; e.en = cg || dg;
      if (cg) begin e.we = cw; e.addr = ca; e.wd = cwd; e.crd = ref_mem[ca]; end
      else if (dg) begin e.we = dw; e.addr = da; e.wd = dwd; end
      if (dg && !dw) begin m_rd = ref_mem[da]; m_rv = 1'b1; end
      else m_rv = 1'b0;
      if (cg && cw) ref_mem[ca] = cwd;
      if (dg && dw) ref_mem[da] = dwd;
    end
    last_dg = dg;
    exp_q.push_back(e);
  endtask

  initial begin
    logic         pend, pw, cr, rr;
    logic [W-1:0] pa, pd;
    // Reset held with a debug request pending
    repeat (2) step(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'hA5);
    // Idle steal: write then read back
    step(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'hA5);
    step(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    // Starvation, no lock
    repeat (6) step(1, 1, 0, 8'h20, 8'h33, 1, 1, 0, 8'h40, 8'h5A);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    // Burst cap with lock and continuous conflict
    repeat (14) step(1, 1, 1, 8'h21, 8'h44, 1, 0, 1, 8'h40, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    // Early release out of a forced episode
    repeat (4) step(1, 1, 0, 8'h22, 8'h00, 1, 1, 1, 8'h41, 8'h77);
    step(1, 1, 0, 8'h40, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(1, 1, 0, 8'h41, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    // Reset mid-burst
    repeat (6) step(1, 1, 1, 8'h23, 8'h99, 1, 0, 1, 8'h41, 8'h00);
    step(0, 1, 1, 8'h23, 8'h99, 1, 0, 1, 8'h41, 8'h00);
    repeat (6) step(1, 1, 0, 8'h23, 8'h00, 1, 0, 1, 8'h42, 8'h00);
    // Randomized traffic with a handshake-respecting debug master
    pend = 0; pw = 0; pa = '0; pd = '0;
    repeat (2000) begin
      if (!pend || last_dg) begin
        pend = ($urandom_range(0, 99) < 60);
        pw   = 1'($urandom_range(0, 1));
        pa   = W'($urandom_range(0, 15));
        pd   = W'($urandom);
      end else if ($urandom_range(0, 99) < 5) pend = 0;
      cr = ($urandom_range(0, 99) < 70);
      rr = ($urandom_range(0, 199) != 0);
      step(rr, cr, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom),
           pend, pw, 1'($urandom_range(0, 1)), pa, pd);
      if (!rr) pend = 0;
    end
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/d_mem_arb.md
# d_mem_arb

Single-port data-memory arbiter between the CPU datapath (one-cycle execution) and a debug/loader master. The CPU owns memory by default, and the debug port takes idle cycles. When `D_MEM_ARB_STARVE_EN` is defined, a starvation counter forces a debug burst and stalls the CPU while it runs. The block sits between the instruction decoder's `en_d_mem`/`d_mem_addr` outputs and the data memory. `cpu_stall` gates PC advance and accumulator/register-file writes.

## Interface
- `WIDTH`, 8, data and address width.
- `STARVE_LIMIT`, 4, number of consecutive conflict cycles (both requesting, debug denied) before debug is forced; must be ≥1.
- `BURST_MAX`, 4, maximum number of debug transfers per forced ownership; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU memory access this cycle (`en_d_mem`).
- `cpu_we`  in  1  CPU write strobe.
- `cpu_addr`  in  WIDTH  CPU address.
- `cpu_wdata`  in  WIDTH  CPU write data.
- `cpu_rdata`  out  WIDTH  equals `mem_rdata` when the CPU is granted, else 0.
- `cpu_stall`  out  1  CPU request denied this cycle; CPU must hold its state.
- `dbg_req`  in  1  debug access request; held until granted.
- `dbg_we`  in  1  debug write strobe.
- `dbg_lock`  in  1  request to keep ownership for a burst.
- `dbg_addr`  in  WIDTH  debug address.
- `dbg_wdata`  in  WIDTH  debug write data.
- `dbg_gnt`  out  1  debug transfer performed this cycle.
- `dbg_rdata`  out  WIDTH  registered read data.
- `dbg_rvalid`  out  1  one-cycle pulse: `dbg_rdata` is valid.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  WIDTH  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_rdata`  in  WIDTH  memory read data; combinational read.

## Operation
- **States:** S_CPU (reset state) and S_DBG. Registers are the state, `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`), `burst_cnt` (width `$clog2(BURST_MAX+1)`), `dbg_rdata` and `dbg_rvalid`.
- **Grants in S_CPU** (combinational):
  - `cpu_gnt = cpu_req`.
  - `dbg_gnt = dbg_req & ~cpu_req`.
  - `cpu_stall = 0`.
- **Starvation counter in S_CPU:**
  - If `dbg_req & cpu_req`, `starve_cnt` increments.
  - When `starve_cnt == STARVE_LIMIT-1` and the conflict is still present, next state is S_DBG, `starve_cnt` clears and `burst_cnt` clears.
  - Any cycle without a conflict clears `starve_cnt`.
- **Grants in S_DBG:**
  - If `dbg_req`: `dbg_gnt = 1`, `cpu_stall = cpu_req`, `burst_cnt` increments.
  - If `~dbg_req`: the CPU is granted as in S_CPU, and the next state is S_CPU.
- **Leaving S_DBG** after a granted transfer: return to S_CPU unless `dbg_lock & (burst_cnt < BURST_MAX-1)`. Every return to S_CPU clears `burst_cnt`.
- **Memory mux:** grant selects `mem_addr`, `mem_wdata` and `mem_we` (requester `_we` AND grant). `mem_en = cpu_gnt | dbg_gnt`. With no grant, all memory outputs are 0.
- **Debug reads:** on a granted debug read (`dbg_gnt & ~dbg_we`), `dbg_rdata <= mem_rdata` and `dbg_rvalid <= 1`; otherwise `dbg_rvalid <= 0`. `dbg_rdata` holds its value between reads.
- **Debug writes** produce no `dbg_rvalid`.

## Timing
- **CPU access latency:** 0 cycles when granted. Read data is combinational, and writes commit on the same rising edge.
- **Debug access:** the grant is combinational in the request cycle. Write data commits at that edge. Read data appears at the next edge, with `dbg_rvalid` high for exactly one cycle.
- **Debug handshake:** the debug master holds `dbg_req`, `dbg_addr`, `dbg_we` and `dbg_wdata` stable until it samples `dbg_gnt` high. Deasserting the request without a grant is permitted; it clears `starve_cnt`.
- **Maximum CPU stall:** `BURST_MAX` consecutive cycles per forced episode. Worst-case debug wait under continuous CPU traffic is `STARVE_LIMIT` cycles.
- **Reset behaviour** (`rst` low, asynchronous): state S_CPU, both counters 0, `dbg_rdata` = 0 and `dbg_rvalid` = 0. While `rst` is low, `dbg_gnt`, `cpu_stall`, `mem_en` and `mem_we` are forced to 0. Reset asserted mid-burst abandons the burst; no partial state survives.
- **Simultaneous CPU and debug request** in S_DBG: the debug request wins and the CPU stalls. A CPU request that was stalled is serviced in the first S_CPU cycle.

## Configuration
- **`D_MEM_ARB_STARVE_EN` defined:** starvation counter, S_DBG and burst logic are present, as described above.
- **`D_MEM_ARB_STARVE_EN` undefined:** strict CPU priority with no S_DBG state and no counters. `cpu_stall` is tied to 0, and `dbg_gnt = dbg_req & ~cpu_req`. `dbg_lock` is ignored. The read capture path is unchanged.

## Test plan
- **Reset:** `rst` low mid-cycle with `dbg_req=1` -> `dbg_gnt=0`, `mem_en=0`, `dbg_rvalid=0` immediately; after release, state S_CPU.
- **Idle steal:** `cpu_req=0`, debug write addr 0x10 data 0xA5, then a debug read of 0x10 -> `dbg_gnt` high in each request cycle; `dbg_rdata=0xA5` with `dbg_rvalid` pulsed one cycle after the read grant.
- **Starvation (`STARVE_LIMIT=4`):** `cpu_req` and `dbg_req` both held -> `dbg_gnt=0` for 4 cycles; 5th cycle `dbg_gnt=1`, `cpu_stall=1`, `mem_addr=dbg_addr`.
- **Burst cap (`BURST_MAX=4`):** `dbg_lock=1`, conflict held -> exactly 4 consecutive debug grants, then a CPU grant with `cpu_stall=0`; `starve_cnt` restarts from 0.
- **Early release:** `dbg_req` drops in S_DBG -> same cycle `cpu_stall=0` and CPU granted; next state S_CPU.
- **Macro undefined:** continuous conflict for 20 cycles -> `dbg_gnt` never asserted and `cpu_stall` always 0; debug granted in the first cycle with `cpu_req=0`.
